debounce_bank: RTL and testbench

Parametrised multi-channel debouncer that replaces single-input button debouncing for the board's pushbuttons and switches in front of the DES control FSM. Each channel runs an independent four-state filter: it accepts a new level only after the level has been held for a programmable number of clocks. Each channel outputs a clean level plus single-cycle rise and fall strobes, so downstream logic needs no edge detectors. An optional input synchroniser makes the block safe for raw asynchronous pins.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 121 ++++++++++++
 rtl/debounce_bank.sv | 44 ++++
 tb/tb_debounce_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_bank slice.
//   state_t              : per-channel filter state (2-bit, all encodings legal)
//   DEFAULT_STABLE_TICKS : default qualification length in clocks
package debounce_pkg;

  typedef enum logic [1:0] {
    IS_1    = 2'b00,
    IS_0    = 2'b01,
    GOING_1 = 2'b10,
    GOING_0 = 2'b11
  } state_t;

  localparam int unsigned DEFAULT_STABLE_TICKS = 1000;

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: four-state filter with a qualification counter,
// registered debounced level and one-cycle rise/fall strobes.
// Optional feature macro: DEBOUNCE_SYNC_EN (two-flop input synchroniser).
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset
//   din    in  raw input level
//   db_out out debounced level
//   rise   out one-cycle strobe on db_out 0->1
//   fall   out one-cycle strobe on db_out 1->0
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic        RESET_VALUE  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned          CNT_W     = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam state_t               RST_STATE = RESET_VALUE ? IS_1 : IS_0;

  logic             w_sample;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_db, w_db_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

`ifdef DEBOUNCE_SYNC_EN
  logic r_sync1, r_sync2;

  // Synchroniser resets to the idle level so reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_db    <= RESET_VALUE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // The counter is compared against STABLE_TICKS-1 before incrementing, so it
  // never exceeds that value; reaching it on an agreeing sample accepts the level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IS_1: begin
        w_cnt_nxt = '0;
        if (!w_sample) w_state_nxt = GOING_0;
      end
      IS_0: begin
        w_cnt_nxt = '0;
        if (w_sample) w_state_nxt = GOING_1;
      end
      GOING_0: begin
        if (w_sample) begin
          w_state_nxt = IS_1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IS_0;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GOING_1: begin
        if (!w_sample) begin
          w_state_nxt = IS_0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IS_1;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign db_out = r_db;
  assign rise   = r_rise;
  assign fall   = r_fall;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: CHANNELS independent debounce_channel filters plus
// an any_change flag (OR of all registered rise/fall strobes).
// Optional feature macro: DEBOUNCE_SYNC_EN (handled inside debounce_channel).
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   din        in  [CHANNELS] raw inputs
//   db_out     out [CHANNELS] debounced levels
//   rise       out [CHANNELS] one-cycle strobes on 0->1
//   fall       out [CHANNELS] one-cycle strobes on 1->0
//   any_change out at least one channel strobes this cycle
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned          CHANNELS     = 4,
  parameter int unsigned          STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic [CHANNELS-1:0]  RESET_VALUE  = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VALUE  (RESET_VALUE[g])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .din    (din[g]),
      .db_out (db_out[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int ST = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'b1111;
  logic [3:0] db_out, rise, fall;
  logic       any_change;

  int passed = 0;
  int total  = 0;

  // per-window recorders (edge index of first event, event counts)
  int fall_first[4], rise_first[4], fall_cnt[4], rise_cnt[4], db0_first[4];
  int any_cnt, any_err;

  debounce_bank #(
    .CHANNELS     (4),
    .STABLE_TICKS (ST),
    .RESET_VALUE  (4'b1111)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .db_out     (db_out),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  task automatic clear_rec();
    for (int c = 0; c < 4; c++) begin
      fall_first[c] = -1; rise_first[c] = -1; db0_first[c] = -1;
      fall_cnt[c] = 0; rise_cnt[c] = 0;
    end
    any_cnt = 0; any_err = 0;
  endtask

  task automatic step_rec(input int k);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      if (fall[c]) begin fall_cnt[c]++; if (fall_first[c] < 0) fall_first[c] = k; end
      if (rise[c]) begin rise_cnt[c]++; if (rise_first[c] < 0) rise_first[c] = k; end
      if (!db_out[c] && db0_first[c] < 0) db0_first[c] = k;
    end
    if (any_change) any_cnt++;
    if (any_change !== (|(rise | fall))) any_err++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({db_out, rise, fall, any_change} !== {4'b1111, 4'b0, 4'b0, 1'b0})
        $display("FAIL reset_hold[%0d]: got db=%b r=%b f=%b any=%b, want db=1111 r=0000 f=0000 any=0",
                 i, db_out, rise, fall, any_change);
      else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({db_out, rise, fall, any_change} !== {4'b1111, 4'b0, 4'b0, 1'b0})
        $display("FAIL reset_after[%0d]: got db=%b r=%b f=%b any=%b, want db=1111 r=0000 f=0000 any=0",
                 i, db_out, rise, fall, any_change);
      else passed++;
    end
  endtask

  task automatic test_fall_rise_ch0();
    clear_rec();
    din[0] = 1'b0;
    for (int k = 0; k < ST + LAT + 6; k++) step_rec(k);
    total++;
    if (fall_first[0] !== ST + LAT || fall_cnt[0] !== 1)
      $display("FAIL fall0_timing: got edge=%0d count=%0d, want edge=%0d count=1", fall_first[0], fall_cnt[0], ST + LAT);
    else passed++;
    total++;
    if (db0_first[0] !== ST + LAT || db_out !== 4'b1110)
      $display("FAIL fall0_level: got first_low=%0d db=%b, want first_low=%0d db=1110", db0_first[0], db_out, ST + LAT);
    else passed++;
    total++;
    if (rise_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] !== 0
        || any_cnt !== 1 || any_err !== 0)
      $display("FAIL fall0_others: got other_strobes=%0d any_cnt=%0d any_err=%0d, want 0 1 0",
               rise_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3],
               any_cnt, any_err);
    else passed++;
    clear_rec();
    din[0] = 1'b1;
    for (int k = 0; k < ST + LAT + 6; k++) step_rec(k);
    total++;
    if (rise_first[0] !== ST + LAT || rise_cnt[0] !== 1 || db_out !== 4'b1111)
      $display("FAIL rise0: got edge=%0d count=%0d db=%b, want edge=%0d count=1 db=1111",
               rise_first[0], rise_cnt[0], db_out, ST + LAT);
    else passed++;
  endtask

  task automatic test_glitch_ch1();
    clear_rec();
    for (int k = 0; k < 30; k++) begin
      if (k == 0) din[1] = 1'b0;
      if (k == ST) din[1] = 1'b1;   // exactly ST low samples: one short
      step_rec(k);
    end
    total++;
    if (fall_cnt[1] !== 0 || rise_cnt[1] !== 0 || any_cnt !== 0 || db0_first[1] !== -1 || db_out !== 4'b1111)
      $display("FAIL glitch1: got fall=%0d rise=%0d any=%0d first_low=%0d db=%b, want 0 0 0 -1 1111",
               fall_cnt[1], rise_cnt[1], any_cnt, db0_first[1], db_out);
    else passed++;
    // a full-length low afterwards must qualify from scratch
    clear_rec();
    din[1] = 1'b0;
    for (int k = 0; k < ST + LAT + 4; k++) step_rec(k);
    total++;
    if (fall_first[1] !== ST + LAT || fall_cnt[1] !== 1 || db_out !== 4'b1101)
      $display("FAIL glitch1_then_fall: got edge=%0d count=%0d db=%b, want edge=%0d count=1 db=1101",
               fall_first[1], fall_cnt[1], db_out, ST + LAT);
    else passed++;
    clear_rec();
    din[1] = 1'b1;
    for (int k = 0; k < ST + LAT + 4; k++) step_rec(k);
    total++;
    if (rise_first[1] !== ST + LAT || db_out !== 4'b1111)
      $display("FAIL glitch1_restore: got edge=%0d db=%b, want edge=%0d db=1111", rise_first[1], db_out, ST + LAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clear_rec();
    for (int k = 0; k < 50; k++) begin
      if (k == 0)  din[3:2] = 2'b00;
      if (k == 20) din[3:2] = 2'b11;
      step_rec(k);
    end
    total++;
    if (fall_first[2] !== ST + LAT || fall_first[3] !== ST + LAT || fall_cnt[2] !== 1 || fall_cnt[3] !== 1)
      $display("FAIL simul_fall: got edges=%0d,%0d counts=%0d,%0d, want %0d,%0d 1,1",
               fall_first[2], fall_first[3], fall_cnt[2], fall_cnt[3], ST + LAT, ST + LAT);
    else passed++;
    total++;
    if (rise_first[2] !== 20 + ST + LAT || rise_first[3] !== 20 + ST + LAT || rise_cnt[2] !== 1 || rise_cnt[3] !== 1)
      $display("FAIL simul_rise: got edges=%0d,%0d counts=%0d,%0d, want %0d,%0d 1,1",
               rise_first[2], rise_first[3], rise_cnt[2], rise_cnt[3], 20 + ST + LAT, 20 + ST + LAT);
    else passed++;
    total++;
    if (any_cnt !== 2 || any_err !== 0 || db_out !== 4'b1111)
      $display("FAIL simul_any: got any_cnt=%0d any_err=%0d db=%b, want 2 0 1111", any_cnt, any_err, db_out);
    else passed++;
  endtask

  task automatic test_reset_mid_filter();
    clear_rec();
    din[0] = 1'b0;
    for (int k = 0; k < 5; k++) step_rec(k);
    rst = 1'b1;
    #1;
    total++;
    if ({db_out, rise, fall, any_change} !== {4'b1111, 4'b0, 4'b0, 1'b0} || any_cnt !== 0)
      $display("FAIL midrst_immediate: got db=%b r=%b f=%b any=%b prior_any=%0d, want 1111 0000 0000 0 0",
               db_out, rise, fall, any_change, any_cnt);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_rec();
    for (int k = 0; k < ST + LAT + 6; k++) step_rec(k);
    total++;
    if (fall_first[0] !== ST + LAT || fall_cnt[0] !== 1 || db0_first[0] !== ST + LAT || any_cnt !== 1)
      $display("FAIL midrst_fall: got edge=%0d count=%0d first_low=%0d any=%0d, want %0d 1 %0d 1",
               fall_first[0], fall_cnt[0], db0_first[0], any_cnt, ST + LAT, ST + LAT);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fall_rise_ch0();
    test_glitch_ch1();
    test_back_to_back();
    test_reset_mid_filter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
